// File: rtl/host_rd_reorder_pkg.sv
// Shared constants and FSM encoding for the host read reorder/split stage.
// Optional feature macro: HOST_RD_REORDER_ERR_EN (see host_rd_reorder.sv).
package host_rd_reorder_pkg;

    localparam int LINE_SHIFT  = 6;
    localparam int DEF_DATA_W  = 512;
    localparam int DEF_ADDR_W  = 48;
    localparam int DEF_BURST_W = 3;
    localparam int DEF_TAG_W   = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

endpackage

// File: rtl/host_rd_reorder_ram.sv
// Line storage for the reorder ring: one write port, one registered read port.
// The read register is reset so the in-order data output starts at zero.
module host_rd_reorder_ram
    import host_rd_reorder_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = DEF_TAG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [TAG_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [TAG_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 2 ** TAG_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/host_rd_reorder.sv
// Splits Avalon read bursts into tagged line requests and returns out-of-order
// line responses in order. Define HOST_RD_REORDER_ERR_EN to enable response checking and err.
module host_rd_reorder
    import host_rd_reorder_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int BURST_W = DEF_BURST_W,
    parameter int TAG_W   = DEF_TAG_W
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset,
    input  logic                     avs_read,
    input  logic [ADDR_W-1:0]        avs_address,
    input  logic [BURST_W-1:0]       avs_burstcount,
    output logic                     avs_waitrequest,
    output logic [DATA_W-1:0]        avs_readdata,
    output logic                     avs_readdatavalid,
    output logic                     rd_req_valid,
    input  logic                     rd_req_ready,
    output logic [ADDR_W-7:0]        rd_req_addr,
    output logic [TAG_W-1:0]         rd_req_tag,
    input  logic                     rd_rsp_valid,
    input  logic [TAG_W-1:0]         rd_rsp_tag,
    input  logic [DATA_W-1:0]        rd_rsp_data,
    output logic                     err
);

    localparam int              LINE_W    = ADDR_W - LINE_SHIFT;
    localparam int              DEPTH     = 2 ** TAG_W;
    localparam logic [TAG_W:0]  DEPTH_CNT = (TAG_W + 1)'(DEPTH);
    localparam logic [TAG_W:0]  CNT_ONE   = (TAG_W + 1)'(1);
    localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);
    localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);
    localparam logic [LINE_W-1:0] LINE_ONE = LINE_W'(1);

    state_t              state_q, state_d;
    logic                init_q;
    logic [TAG_W-1:0]    head_q, tail_q;
    logic [TAG_W:0]      free_q, free_d;
    logic [BURST_W-1:0]  remain_q;
    logic [LINE_W-1:0]   addr_q;
    logic [DEPTH-1:0]    vld_q, vld_d;
    logic                dv_q;

    logic                waitreq;
    logic                accept;
    logic                issue;
    logic                req_valid;
    logic                drain;
    logic                rsp_ok;
    logic                wr_en;
    logic [TAG_W:0]      bc_ext;
    logic                addr_lsb_unused;

    // Byte offset within the line carries no information for line requests.
    assign addr_lsb_unused = ^avs_address[LINE_SHIFT-1:0];
    assign bc_ext          = (TAG_W + 1)'(avs_burstcount);

    // Handshakes: a burst transfers when avs_read && !avs_waitrequest; a line
    // request transfers when rd_req_valid && rd_req_ready; responses and the
    // in-order data stream are valid-only since slots are reserved up front.
    always_comb begin
        state_d   = state_q;
        waitreq   = 1'b1;
        accept    = 1'b0;
        issue     = 1'b0;
        req_valid = 1'b0;
        case (state_q)
            IDLE: begin
                waitreq = !init_q || (free_q < bc_ext) ||
                          (avs_read && (avs_burstcount == '0));
                accept  = avs_read && !waitreq;
                if (accept) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                req_valid = 1'b1;
                issue     = rd_req_ready;
                if (rd_req_ready && (remain_q == BURST_ONE)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign drain = vld_q[head_q];
    assign wr_en = rd_rsp_valid && rsp_ok;

    always_comb begin
        vld_d = vld_q;
        if (drain) begin
            vld_d[head_q] = 1'b0;
        end
        if (wr_en) begin
            vld_d[rd_rsp_tag] = 1'b1;
        end
    end

    always_comb begin
        free_d = free_q;
        if (accept) begin
            free_d = free_d - bc_ext;
        end
        if (drain) begin
            free_d = free_d + CNT_ONE;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q  <= IDLE;
            init_q   <= 1'b0;
            head_q   <= '0;
            tail_q   <= '0;
            free_q   <= DEPTH_CNT;
            remain_q <= '0;
            addr_q   <= '0;
            vld_q    <= '0;
            dv_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
            free_q  <= free_d;
            vld_q   <= vld_d;
            dv_q    <= drain;
            if (drain) begin
                head_q <= head_q + TAG_ONE;
            end
            if (issue) begin
                tail_q <= tail_q + TAG_ONE;
            end
            if (accept) begin
                addr_q   <= avs_address[ADDR_W-1:LINE_SHIFT];
                remain_q <= avs_burstcount;
            end else if (issue) begin
                addr_q   <= addr_q + LINE_ONE;
                remain_q <= remain_q - BURST_ONE;
            end
        end
    end

`ifdef HOST_RD_REORDER_ERR_EN
    logic [TAG_W:0]   out_cnt_q;
    logic [TAG_W-1:0] rsp_off;
    logic             err_q;

    // A tag is outstanding when its distance from head is below the number of
    // issued-but-undrained lines; that count also covers a completely full ring.
    assign rsp_off = rd_rsp_tag - head_q;
    assign rsp_ok  = ({1'b0, rsp_off} < out_cnt_q) && !vld_q[rd_rsp_tag];

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            out_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            case ({issue, drain})
                2'b10:   out_cnt_q <= out_cnt_q + CNT_ONE;
                2'b01:   out_cnt_q <= out_cnt_q - CNT_ONE;
                default: out_cnt_q <= out_cnt_q;
            endcase
            if (rd_rsp_valid && !rsp_ok) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign rsp_ok = 1'b1;
    assign err    = 1'b0;
`endif

    host_rd_reorder_ram #(
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W)
    ) u_ram (
        .clk     (clk_clk),
        .rst     (reset_reset),
        .wr_en   (wr_en),
        .wr_addr (rd_rsp_tag),
        .wr_data (rd_rsp_data),
        .rd_en   (drain),
        .rd_addr (head_q),
        .rd_data (avs_readdata)
    );

    assign avs_waitrequest   = waitreq;
    assign avs_readdatavalid = dv_q;
    assign rd_req_valid      = req_valid;
    assign rd_req_addr       = addr_q;
    assign rd_req_tag        = tail_q;

endmodule

// File: tb/tb_host_rd_reorder.sv
// Bench for host_rd_reorder: bench-side host model, request/data scoreboards,
// directed corner cases and randomized bursts with random response order.
module tb_host_rd_reorder;

    localparam int DATA_W  = 512;
    localparam int ADDR_W  = 48;
    localparam int BURST_W = 3;
    localparam int TAG_W   = 5;
    localparam int LINE_W  = ADDR_W - 6;

    localparam int RSP_HOLD    = 0;
    localparam int RSP_INORDER = 1;
    localparam int RSP_RANDOM  = 2;

    typedef struct packed {
        logic [LINE_W-1:0] addr;
        logic [TAG_W-1:0]  tag;
    } req_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                avs_read = 1'b0;
    logic [ADDR_W-1:0]   avs_address = '0;
    logic [BURST_W-1:0]  avs_burstcount = '0;
    logic                avs_waitrequest;
    logic [DATA_W-1:0]   avs_readdata;
    logic                avs_readdatavalid;
    logic                rd_req_valid;
    logic                rd_req_ready = 1'b0;
    logic [LINE_W-1:0]   rd_req_addr;
    logic [TAG_W-1:0]    rd_req_tag;
    logic                rd_rsp_valid = 1'b0;
    logic [TAG_W-1:0]    rd_rsp_tag = '0;
    logic [DATA_W-1:0]   rd_rsp_data = '0;
    logic                err;

    int n_checks = 0;
    int n_pass   = 0;

    req_t              exp_req_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [TAG_W-1:0]  pend_tag_q[$];
    logic [DATA_W-1:0] pend_data_q[$];
    logic [TAG_W-1:0]  force_q[$];
    logic [TAG_W-1:0]  tail_m = '0;
    int                rsp_mode  = RSP_HOLD;
    int                ready_pct = 100;

    host_rd_reorder dut (
        .clk_clk           (clk),
        .reset_reset       (rst),
        .avs_read          (avs_read),
        .avs_address       (avs_address),
        .avs_burstcount    (avs_burstcount),
        .avs_waitrequest   (avs_waitrequest),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .rd_req_valid      (rd_req_valid),
        .rd_req_ready      (rd_req_ready),
        .rd_req_addr       (rd_req_addr),
        .rd_req_tag        (rd_req_tag),
        .rd_rsp_valid      (rd_rsp_valid),
        .rd_rsp_tag        (rd_rsp_tag),
        .rd_rsp_data       (rd_rsp_data),
        .err               (err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- check helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic check_data(input string name, input logic [DATA_W-1:0] act,
                              input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    function automatic logic [DATA_W-1:0] rand_line();
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // ---------------- host model: captures requests, returns responses ----------------
    always @(negedge clk) begin
        logic [DATA_W-1:0] d;
        req_t e;
        if (!rst && rd_req_valid && rd_req_ready) begin
            if (exp_req_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_req: got addr 0x%0h tag %0d, required no request",
                         rd_req_addr, rd_req_tag);
            end else begin
                e = exp_req_q.pop_front();
                check("req_addr", 64'(rd_req_addr), 64'(e.addr));
                check("req_tag", 64'(rd_req_tag), 64'(e.tag));
            end
            d = rand_line();
            pend_tag_q.push_back(rd_req_tag);
            pend_data_q.push_back(d);
            exp_q.push_back(d);
        end
    end

    always @(posedge clk) begin
        logic [TAG_W-1:0] send_tag;
        int idx;
        #1;
        rd_rsp_valid = 1'b0;
        rd_req_ready = ($urandom_range(99) < ready_pct);
        if (!rst) begin
            if (force_q.size() != 0) begin
                send_tag = force_q.pop_front();
                idx = -1;
                foreach (pend_tag_q[i]) if (idx < 0 && pend_tag_q[i] == send_tag) idx = i;
                rd_rsp_valid = 1'b1;
                rd_rsp_tag   = send_tag;
                if (idx >= 0) begin
                    rd_rsp_data = pend_data_q[idx];
                    pend_tag_q.delete(idx);
                    pend_data_q.delete(idx);
                end else begin
                    rd_rsp_data = rand_line();
                end
            end else if (pend_tag_q.size() != 0 &&
                         (rsp_mode == RSP_INORDER ||
                          (rsp_mode == RSP_RANDOM && $urandom_range(1) == 1))) begin
                idx = (rsp_mode == RSP_INORDER) ? 0 : int'($urandom_range(pend_tag_q.size() - 1));
                rd_rsp_valid = 1'b1;
                rd_rsp_tag   = pend_tag_q[idx];
                rd_rsp_data  = pend_data_q[idx];
                pend_tag_q.delete(idx);
                pend_data_q.delete(idx);
            end
        end
    end

    // ---------------- scoreboard monitor for the in-order data stream ----------------
    always @(negedge clk) begin
        logic [DATA_W-1:0] e;
        if (avs_readdatavalid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_readdatavalid: got data 0x%0h, required no output",
                         avs_readdata);
            end else begin
                e = exp_q.pop_front();
                check_data("readdata", avs_readdata, e);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic burst(input logic [ADDR_W-1:0] a, input int bc);
        int c = 0;
        logic accepted = 1'b0;
        logic [LINE_W-1:0] la = a[ADDR_W-1:6];
        @(posedge clk); #1;
        avs_read       = 1'b1;
        avs_address    = a;
        avs_burstcount = BURST_W'(bc);
        while (c < 200) begin
            @(negedge clk);
            if (!avs_waitrequest) begin
                accepted = 1'b1;
                break;
            end
            c++;
        end
        check("burst_accept", 64'(accepted), 64'd1);
        if (accepted) begin
            for (int i = 0; i < bc; i++) begin
                exp_req_q.push_back('{addr: la + LINE_W'(i), tag: tail_m});
                tail_m = tail_m + TAG_W'(1);
            end
        end
        @(posedge clk); #1;
        avs_read       = 1'b0;
        avs_burstcount = '0;
    endtask

    task automatic hold_check(input string name, input int bc, input int n);
        @(posedge clk); #1;
        avs_read       = 1'b1;
        avs_address    = 48'h0000_0000_8000;
        avs_burstcount = BURST_W'(bc);
        repeat (n) begin
            @(negedge clk);
            check(name, 64'(avs_waitrequest), 64'd1);
        end
        @(posedge clk); #1;
        avs_read       = 1'b0;
        avs_burstcount = '0;
    endtask

    task automatic wait_pending(input int n);
        int c = 0;
        while (pend_tag_q.size() < n && c < 500) begin
            @(negedge clk);
            c++;
        end
        check("pending_reached", 64'(pend_tag_q.size() >= n), 64'd1);
    endtask

    task automatic wait_drain();
        int c = 0;
        while ((exp_q.size() != 0 || pend_tag_q.size() != 0 || exp_req_q.size() != 0) && c < 4000) begin
            @(negedge clk);
            c++;
        end
        repeat (4) @(negedge clk);
        check("drain_exp_empty", 64'(exp_q.size()), 64'd0);
        check("drain_req_empty", 64'(exp_req_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string p);
        check({p, "_waitreq"}, 64'(avs_waitrequest), 64'd1);
        check({p, "_readdatavalid"}, 64'(avs_readdatavalid), 64'd0);
        check_data({p, "_readdata"}, avs_readdata, '0);
        check({p, "_req_valid"}, 64'(rd_req_valid), 64'd0);
        check({p, "_req_addr"}, 64'(rd_req_addr), 64'd0);
        check({p, "_req_tag"}, 64'(rd_req_tag), 64'd0);
        check({p, "_err"}, 64'(err), 64'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [TAG_W-1:0] base;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        check("waitreq_before_first_edge", 64'(avs_waitrequest), 64'd1);
        @(negedge clk);
        check("waitreq_after_first_edge", 64'(avs_waitrequest), 64'd0);

        // Single burst, in-order responses: four back-to-back outputs, latency 2.
        burst(48'h1000, 4);
        wait_pending(4);
        for (int i = 0; i < 4; i++) force_q.push_back(pend_tag_q[i]);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check("inorder_dv_timing", 64'(avs_readdatavalid), 64'(k >= 3 && k <= 6));
        end
        wait_drain();
        check("free_restored_1", 64'(dut.free_q), 64'd32);

        // Same burst, responses 3,1,0,2: data still in order, first output 2 cycles after tag 0.
        base = tail_m;
        burst(48'h1000, 4);
        wait_pending(4);
        force_q.push_back(base + TAG_W'(3));
        force_q.push_back(base + TAG_W'(1));
        force_q.push_back(base);
        force_q.push_back(base + TAG_W'(2));
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check("reorder_dv_timing", 64'(avs_readdatavalid), 64'(k >= 5 && k <= 8));
        end
        wait_drain();

        // Fill the ring: eight bursts of four, then the ninth must wait for four drains.
        for (int b = 0; b < 8; b++) burst(48'h2_0000 + 48'(b) * 48'h100, 4);
        wait_pending(32);
        hold_check("full_ring_hold", 4, 5);
        force_q.push_back(pend_tag_q[0]);
        repeat (4) @(negedge clk);
        hold_check("one_drain_hold", 4, 4);
        for (int i = 0; i < 3; i++) force_q.push_back(pend_tag_q[i]);
        burst(48'h3_0000, 4);
        rsp_mode = RSP_INORDER;
        wait_drain();
        check("free_restored_2", 64'(dut.free_q), 64'd32);

        // Zero burstcount: never accepted while read is high, no stall while read is low.
        hold_check("bc0_hold", 0, 4);
        @(negedge clk);
        check("bc0_idle_waitreq", 64'(avs_waitrequest), 64'd0);

        // Tag wrap with single-line bursts and immediate responses.
        for (int b = 0; b < 40; b++) burst({16'h0, $urandom} & 48'hFFFF_FFFF_FFC0, 1);
        // Line address wrap at the top of the address space.
        burst(48'hFFFF_FFFF_FFC0, 3);
        wait_drain();

        // Randomized bursts, random request backpressure and random response order.
        rsp_mode  = RSP_RANDOM;
        ready_pct = 70;
        for (int b = 0; b < 60; b++) begin
            burst({$urandom, $urandom}, $urandom_range(1, 7));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        wait_drain();
        check("free_restored_3", 64'(dut.free_q), 64'd32);

        // Reset in ISSUE with two lines already issued.
        rsp_mode  = RSP_HOLD;
        ready_pct = 100;
        burst(48'h4_0000, 4);
        @(posedge clk);
        @(posedge clk); #2 rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        exp_req_q.delete();
        exp_q.delete();
        pend_tag_q.delete();
        pend_data_q.delete();
        force_q.delete();
        tail_m = '0;
        @(posedge clk); #2 rst = 1'b0;
        rsp_mode = RSP_INORDER;
        burst(48'h5_0040, 2);
        wait_drain();

`ifdef HOST_RD_REORDER_ERR_EN
        // Response for a tag that is not outstanding is dropped and flags err.
        rsp_mode = RSP_HOLD;
        burst(48'h6_0000, 4);
        wait_pending(4);
        base = pend_tag_q[0];
        force_q.push_back(base + TAG_W'(9));
        repeat (4) @(negedge clk);
        check("err_set", 64'(err), 64'd1);
        for (int i = 0; i < 4; i++) force_q.push_back(pend_tag_q[i]);
        wait_drain();
        check("err_sticky", 64'(err), 64'd1);
`else
        check("err_tied_low", 64'(err), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
